// File: rtl/ahb_dtcm_slave.sv
// AHB-Lite responder in front of a 32-bit word data memory (DTCM).
// Pipelined address/data phases, fixed wait states, two-cycle ERROR for illegal sizes/alignment.
module ahb_dtcm_slave #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   state_t              r_state;
   state_t              w_state_next;
   state_t              w_launch_state;
   logic [1:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_off;
   logic                r_write;
   logic [1:0]          r_size;

   logic                w_req;
   logic                w_err;
   logic                w_take;
   logic                w_done;
   logic [3:0]          w_lane_en;
   logic [3:0]          w_we;
   logic                w_unused;

   logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

   assign w_unused = ^{hburst, hprot, htrans[0], haddr[31:ADDR_W+2], hsize[2]};

   assign w_req = hsel & htrans[1] & hready;
   assign w_err = (hsize > 3'd2)
                | ((hsize == 3'd1) & haddr[0])
                | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
   assign w_launch_state = w_req ? (w_err ? S_ERR1 : S_DATA) : S_IDLE;

   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      w_done       = 1'b0;
      hreadyout    = 1'b1;
      hresp        = RESP_OKAY;
      case (r_state)
         S_IDLE: begin
            w_take       = w_req;
            w_state_next = w_launch_state;
         end
         S_DATA: begin
            hreadyout = (r_cnt == 2'd0);
            if (r_cnt == 2'd0) begin
               w_done       = 1'b1;
               w_take       = w_req;
               w_state_next = w_launch_state;
            end
         end
         S_ERR1: begin
            hreadyout    = 1'b0;
            hresp        = RESP_ERROR;
            w_state_next = S_ERR2;
         end
         S_ERR2: begin
            hresp        = RESP_ERROR;
            w_take       = w_req;
            w_state_next = w_launch_state;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      hrdata = 32'h0;
      if (w_done && !r_write)
         hrdata = r_mem[r_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_addr  <= '0;
         r_off   <= 2'd0;
         r_write <= 1'b0;
         r_size  <= 2'd0;
      end else begin
         r_state <= w_state_next;
         if (w_take) begin
            r_addr  <= haddr[ADDR_W+1:2];
            r_off   <= haddr[1:0];
            r_write <= hwrite;
            r_size  <= hsize[1:0];
         end
         if (w_take && !w_err)
            r_cnt <= 2'(WAIT_STATES);
         else if (r_state == S_DATA && r_cnt != 2'd0)
            r_cnt <= r_cnt - 2'd1;
      end
   end

   // Errored transfers never reach S_DATA, so only sizes 0..2 appear here.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign w_lane_en[gi] = (r_size == 2'd2)
                              | ((r_size == 2'd1) & (r_off[1] == LANE[1]))
                              | ((r_size == 2'd0) & (r_off == LANE));
         assign w_we[gi] = w_done & r_write & w_lane_en[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_we[i])
            r_mem[r_addr][i*8 +: 8] <= hwdata[i*8 +: 8];
      end
   end

endmodule

// File: tb/tb_ahb_dtcm_slave.sv
// Directed bench for ahb_dtcm_slave: vector table on a zero-wait instance,
// hand-written sequences on a two-wait instance for wait, error and reset corners.
module tb_ahb_dtcm_slave;

   localparam logic [1:0] IDL = 2'b00;
   localparam logic [1:0] BSY = 2'b01;
   localparam logic [1:0] NSQ = 2'b10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel0, hsel2;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        rdy0, rdy2;
   logic [1:0]  resp0, resp2;
   logic [31:0] rd0, rd2;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   ahb_dtcm_slave #(.ADDR_W(12), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011),
      .hwdata(hwdata), .hready(rdy0), .hreadyout(rdy0), .hresp(resp0), .hrdata(rd0)
   );

   ahb_dtcm_slave #(.ADDR_W(12), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .rst_n(rst_n), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(3'b001), .hprot(4'b0011),
      .hwdata(hwdata), .hready(rdy2), .hreadyout(rdy2), .hresp(resp2), .hrdata(rd2)
   );

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rdy;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic s, input logic [1:0] tr, input logic w,
                               input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                               input logic er, input logic [1:0] ers, input logic [31:0] ed);
      vec_t v;
      v.sel = s; v.trans = tr; v.wr = w; v.size = sz; v.addr = a; v.wdata = wd;
      v.exp_rdy = er; v.exp_resp = ers; v.exp_rdata = ed;
      return v;
   endfunction

   // Drive one cycle's inputs just after the rising edge, return at the falling edge.
   task automatic drv(input logic s0, input logic s2, input logic [1:0] tr, input logic w,
                      input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      hsel0 = s0; hsel2 = s2; htrans = tr; hwrite = w; hsize = sz; haddr = a; hwdata = wd;
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic r, input logic [1:0] rs, input logic [31:0] d,
                      input logic er, input logic [1:0] ers, input logic [31:0] ed);
      n_vec++;
      if (r !== er || rs !== ers || d !== ed) begin
         n_miss++;
         $display("FAIL %s: got rdy=%0b resp=%0d rdata=%08h, want rdy=%0b resp=%0d rdata=%08h",
                  nm, r, rs, d, er, ers, ed);
      end else begin
         $display("ok   %s: rdy=%0b resp=%0d rdata=%08h", nm, r, rs, d);
      end
   endtask

   task automatic chk2(input string nm, input logic er, input logic [1:0] ers, input logic [31:0] ed);
      chk(nm, rdy2, resp2, rd2, er, ers, ed);
   endtask

   initial begin
      rst_n = 1'b0;
      hsel0 = 1'b0; hsel2 = 1'b0; htrans = IDL; hwrite = 1'b0;
      hsize = 3'd0; haddr = 32'h0; hwdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ws0", rdy0, resp0, rd0, 1'b1, 2'd0, 32'h0);
      chk2("reset_ws2", 1'b1, 2'd0, 32'h0);
      rst_n = 1'b1;

      // Each row: address-phase inputs, data-phase hwdata, outputs expected in that cycle.
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(0, IDL, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 1, 2, 32'h10, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 1, 2, 32'h10, 32'h0,        1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(1, NSQ, 1, 0, 32'h11, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 1, 1, 32'h12, 32'h1122AA33, 1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 0, 2, 32'h10, 32'h55667788, 1, 0, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'h0,        1, 0, 32'h5566AA00));
      vecs.push_back(mk(1, NSQ, 1, 1, 32'h13, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'hFFFFFFFF, 0, 1, 32'h0));
      vecs.push_back(mk(1, NSQ, 0, 2, 32'h02, 32'hFFFFFFFF, 1, 1, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'h0,        0, 1, 32'h0));
      vecs.push_back(mk(1, NSQ, 1, 3, 32'h10, 32'h0,        1, 1, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'hFFFFFFFF, 0, 1, 32'h0));
      vecs.push_back(mk(1, NSQ, 0, 2, 32'h10, 32'hFFFFFFFF, 1, 1, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'h0,        1, 0, 32'h5566AA00));
      vecs.push_back(mk(0, NSQ, 1, 2, 32'h10, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, BSY, 1, 2, 32'h10, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(1, NSQ, 0, 2, 32'h10, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk(0, IDL, 0, 0, 32'h0,  32'h0,        1, 0, 32'h5566AA00));

      foreach (vecs[i]) begin
         drv(vecs[i].sel, 1'b0, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("ws0_vec%0d", i), rdy0, resp0, rd0,
             vecs[i].exp_rdy, vecs[i].exp_resp, vecs[i].exp_rdata);
      end

      // Two wait states: store with hwdata changing during waits, then load it back.
      drv(0, 1, NSQ, 1, 2, 32'h20, 32'h0);        chk2("ws2_st_addr", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'hBAD0BAD0); chk2("ws2_st_wait1", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'hBAD1BAD1); chk2("ws2_st_wait2", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h12345678); chk2("ws2_st_done", 1, 0, 32'h0);
      drv(0, 1, NSQ, 0, 2, 32'h20, 32'h0);        chk2("ws2_ld_addr", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_ld_wait1", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_ld_wait2", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_ld_data", 1, 0, 32'h12345678);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_ld_after", 1, 0, 32'h0);

      // Error response carries no wait states.
      drv(0, 1, NSQ, 0, 2, 32'h21, 32'h0);        chk2("ws2_err_addr", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_err1", 0, 1, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_err2", 1, 1, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("ws2_err_idle", 1, 0, 32'h0);

      // Reset asserted in the middle of a store's wait cycles.
      drv(0, 1, NSQ, 1, 2, 32'h20, 32'h0);        chk2("rst_st_addr", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'hCAFEF00D); chk2("rst_st_wait1", 0, 0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk2("rst_async", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'hCAFEF00D); chk2("rst_held", 1, 0, 32'h0);
      rst_n = 1'b1;
      drv(0, 1, IDL, 0, 0, 32'h0,  32'hCAFEF00D); chk2("rst_released", 1, 0, 32'h0);
      drv(0, 1, NSQ, 0, 2, 32'h20, 32'h0);        chk2("rst_ld_addr", 1, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("rst_ld_wait1", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("rst_ld_wait2", 0, 0, 32'h0);
      drv(0, 1, IDL, 0, 0, 32'h0,  32'h0);        chk2("rst_ld_data", 1, 0, 32'h12345678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ahb_dtcm_slave.md
# ahb_dtcm_slave

AHB-Lite responder fronting a register-array data memory (DTCM). It sits on the far side of the core's data-side AHB master port (`d_h*`), typically behind the bus decoder. It answers load and store transfers of byte, halfword or word size, with a configurable number of wait states. It returns a two-cycle ERROR response for misaligned or oversized transfers.

## Interface
Parameters:
- ADDR_W, 12, word-address bits; memory depth is 2^ADDR_W 32-bit words, using haddr[ADDR_W+1:2].
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase; legal range 0..3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- hsel  in  1  slave select from the decoder.
- haddr  in  32  transfer address.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  in  1  1 = store.
- hsize  in  3  0 = byte, 1 = half, 2 = word; greater than 2 is illegal.
- hburst  in  3  ignored; every beat is handled independently.
- hprot  in  4  ignored.
- hwdata  in  32  store data, valid in the data phase.
- hready  in  1  bus-level HREADY, used for address-phase qualification.
- hreadyout  out  1  this slave's ready.
- hresp  out  2  00 = OKAY, 01 = ERROR.
- hrdata  out  32  load data.

## Operation
- **Accept.** An address phase is accepted when hsel & htrans[1] & hready are all 1 at a rising edge.
  - On accept, register: word address, byte offset haddr[1:0], hwrite, hsize, and an error flag.
- **Error flag.** The flag is set when any of the following holds:
  - hsize > 2;
  - hsize = 1 and haddr[0] = 1;
  - hsize = 2 and haddr[1:0] ≠ 0.
- **IDLE/BUSY, or hsel = 0.** No transfer is captured. The next cycle is an OKAY, zero-wait cycle.
- **FSM states:** S_IDLE, S_DATA, S_ERR1, S_ERR2.
  - S_IDLE: hreadyout = 1, hresp = OKAY.
    - Accept with error → S_ERR1.
    - Accept without error → S_DATA, with the wait counter loaded with WAIT_STATES.
  - S_DATA: hreadyout = (cnt == 0); cnt decrements each cycle while it is nonzero.
    - On the cycle where cnt == 0, the transfer completes.
    - If a new accept happens in that same cycle, go to S_DATA or S_ERR1 for the new transfer; otherwise go to S_IDLE.
  - S_ERR1: hreadyout = 0, hresp = ERROR → S_ERR2.
  - S_ERR2: hreadyout = 1, hresp = ERROR.
    - An accept in this cycle is honoured exactly as in S_IDLE.
    - Otherwise → S_IDLE.
- **Store.** The store commits at the completing edge of the data phase, using hwdata and byte enables.
  - Byte: lane haddr[1:0].
  - Half: lanes {off+1, off}.
  - Word: all four lanes.
  - Lanes not enabled are preserved.
- **Load.** hrdata = mem[captured word address], as the full 32-bit word, during an S_DATA read cycle with cnt == 0.
  - The master performs lane extraction and sign extension.
  - hrdata = 0 in every other cycle.
- **Errored transfers** never read or write memory.
- **Memory array** is not reset; contents are undefined until written.

## Timing
- **Reset values:** state S_IDLE, cnt = 0, hreadyout = 1, hresp = 00, hrdata = 0.
- **Reset mid-operation:** asserting rst_n low aborts any data phase immediately. A pending store is discarded and memory is unchanged.
- **Latency:** a data phase lasts WAIT_STATES+1 cycles after the address phase. With WAIT_STATES = 0, a load's data arrives in the cycle immediately following the address phase.
- **Pipelining:** back-to-back transfers are pipelined; a new address phase overlaps the completing data phase.
- **Store followed by load to the same word:** the store commits at the edge that accepts the load. The load therefore returns the updated word, with no stall.
- **While hreadyout = 0**, a new address phase cannot be accepted, because bus hready is low.
- **Error response:** exactly two cycles, with hresp = ERROR in both and hreadyout low only in the first.
- **hwdata** is sampled only at the completing edge; values in earlier wait cycles are ignored.

## Test plan
- Reset, then idle for 5 cycles → hreadyout = 1, hresp = 00, hrdata = 0 throughout.
- WAIT_STATES = 0: word store 0xDEADBEEF to 0x10, then word load from 0x10 back-to-back → load data phase returns 0xDEADBEEF in the next cycle with hreadyout = 1 and no stall.
- Byte store 0xAA to 0x11, then half store 0x5566 to 0x12 over an initial 0x00000000 → word load from 0x10 returns 0x5566AA00.
- Half store to 0x13, then word load to 0x02, then hsize = 3 → each produces ERROR with hreadyout 0 then 1. Memory is unchanged; verified by a subsequent word load from 0x10.
- WAIT_STATES = 2: word load → hreadyout low for exactly 2 cycles, then data in the 3rd. hwdata changed during the wait cycles of a store → only the final-cycle value is written.
- Assert rst_n mid-wait during a store to 0x20 (prior value 0x12345678) → outputs return to reset values immediately, and a later load from 0x20 returns 0x12345678.
